// File: rtl/snake_pkg.sv
// Shared direction encoding for the snake game: one-hot direction codes,
// button index mapping and the reversal helper.
package snake_pkg;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0100;
   localparam logic [3:0] DIR_DOWN  = 4'b1000;
   localparam logic [3:0] DIR_RESET = DIR_RIGHT;

   // Button vector indices line up with the one-hot direction bits.
   localparam int BTN_UP    = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 2;
   localparam int BTN_DOWN  = 3;

   function automatic logic [3:0] dir_opposite(input logic [3:0] dir);
      logic [3:0] opp;
      case (dir)
         DIR_UP:    opp = DIR_DOWN;
         DIR_DOWN:  opp = DIR_UP;
         DIR_LEFT:  opp = DIR_RIGHT;
         DIR_RIGHT: opp = DIR_LEFT;
         default:   opp = 4'b0000;
      endcase
      return opp;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;

   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      // Any cycle where the synced level agrees with the accepted one restarts the count.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            press_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/direction_ctrl.sv
// Snake direction producer: debounced button presses are arbitrated, filtered
// against reversal, held pending and committed once per move_tick period.
module direction_ctrl
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TICK_CYCLES     = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_down,
   output logic [3:0] direction,
   output logic       move_tick
);

   localparam int TW = $clog2(TICK_CYCLES);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

   logic [3:0] btn_raw;
   logic [3:0] press;
   logic [3:0] unused_level;

   assign btn_raw = {btn_down, btn_right, btn_left, btn_up};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .rst     (rst),
         .btn_raw (btn_raw[i]),
         .level   (unused_level[i]),
         .press   (press[i])
      );
   end

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    direction_q, direction_d;
   logic [3:0]    pend_dir_q, pend_dir_d;
   logic          pend_valid_q, pend_valid_d;
   logic          move_tick_q, move_tick_d;
   logic [3:0]    sel;
   logic          accept;
   logic          commit;

   always_comb begin
      sel = 4'b0000;
      if      (press[BTN_UP])    sel = DIR_UP;
      else if (press[BTN_RIGHT]) sel = DIR_RIGHT;
      else if (press[BTN_DOWN])  sel = DIR_DOWN;
      else if (press[BTN_LEFT])  sel = DIR_LEFT;

      // Reversal is judged against the committed direction, never the pending one.
      accept = (sel != 4'b0000) && (sel != dir_opposite(direction_q));
      commit = (tick_cnt_q == TICK_MAX);

      tick_cnt_d   = commit ? '0 : tick_cnt_q + TW'(1);
      move_tick_d  = commit;
      direction_d  = direction_q;
      pend_valid_d = pend_valid_q;
      pend_dir_d   = pend_dir_q;

      if (commit) begin
         if (pend_valid_q) direction_d = pend_dir_q;
         pend_valid_d = 1'b0;
      end
      // A press landing on the commit edge reloads pending for the next move.
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_dir_d   = sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q   <= '0;
         direction_q  <= DIR_RESET;
         pend_dir_q   <= DIR_RESET;
         pend_valid_q <= 1'b0;
         move_tick_q  <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         direction_q  <= direction_d;
         pend_dir_q   <= pend_dir_d;
         pend_valid_q <= pend_valid_d;
         move_tick_q  <= move_tick_d;
      end
   end

   assign direction = direction_q;
   assign move_tick = move_tick_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed scenarios plus random button activity, checked every cycle against
// a behavioural model built from sample windows and tick arithmetic.
module tb_direction_ctrl;

   localparam int DEB  = 4;
   localparam int TICK = 10;
   localparam logic [3:0] UP = 4'b0001, LEFT = 4'b0010, RIGHT = 4'b0100, DOWN = 4'b1000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic [3:0] direction;
   logic       move_tick;
   int         errors = 0;
   int         checks = 0;

   direction_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn[0]),
      .btn_left  (btn[1]),
      .btn_right (btn[2]),
      .btn_down  (btn[3]),
      .direction (direction),
      .move_tick (move_tick)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [3:0] m_dir, m_pd, m_lvl, m_prs;
   logic       m_tick, m_pv;
   logic [DEB:0] hist [4];   // hist[b][j] = raw sample taken j+1 edges ago
   int         m_edges;

   function automatic logic [3:0] opp(input logic [3:0] d);
      case (d)
         UP: return DOWN;
         DOWN: return UP;
         LEFT: return RIGHT;
         RIGHT: return LEFT;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] pick(input logic [3:0] p);
      logic [3:0] order [4];
      order[0] = UP; order[1] = RIGHT; order[2] = DOWN; order[3] = LEFT;
      for (int k = 0; k < 4; k++)
         if ((p & order[k]) != 4'b0000) return order[k];
      return 4'b0000;
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [3:0] s;
      logic       a, diff;
      if (rst) begin
         m_dir = RIGHT; m_pd = RIGHT; m_pv = 1'b0; m_tick = 1'b0;
         m_lvl = 4'b0000; m_prs = 4'b0000; m_edges = 0;
         for (int b = 0; b < 4; b++) hist[b] = '0;
      end else begin
         m_edges++;
         s = pick(m_prs);
         a = (s != 4'b0000) && (s != opp(m_dir));
         m_tick = (m_edges % TICK) == 0;
         if (m_tick) begin
            if (m_pv) m_dir = m_pd;
            m_pv = 1'b0;
         end
         if (a) begin
            m_pv = 1'b1;
            m_pd = s;
         end
         // Level flips once DEB consecutive synced samples disagree with it.
         for (int b = 0; b < 4; b++) begin
            diff = 1'b1;
            for (int j = 1; j <= DEB; j++)
               if (hist[b][j] == m_lvl[b]) diff = 1'b0;
            m_prs[b] = diff && !m_lvl[b];
            if (diff) m_lvl[b] = ~m_lvl[b];
            hist[b] = {hist[b][DEB-1:0], btn[b]};
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      chk("model_dir", direction, m_dir);
      chk("model_tick", {3'b000, move_tick}, {3'b000, m_tick});
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      #1;
      chk("rst_dir", direction, RIGHT);
      chk("rst_tick", {3'b000, move_tick}, 4'b0000);
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic run_to(input int e);
      for (int i = 0; i < 4 * TICK && m_edges < e; i++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #2;
      do_reset(2);

      // 1: idle, ticks on edge 10, 20, 30
      for (int i = 1; i <= 3 * TICK; i++) begin
         step();
         if (i % TICK == 0) begin
            chk("t1_tick", {3'b000, move_tick}, 4'b0001);
            chk("t1_dir", direction, RIGHT);
         end
      end

      // 2: glitch then long hold on up
      do_reset(2);
      btn[0] = 1'b1; step(); step(); btn[0] = 1'b0;
      run_to(10);
      chk("t2_glitch_dir", direction, RIGHT);
      step();
      btn[0] = 1'b1; repeat (8) step(); btn[0] = 1'b0;
      run_to(20);
      chk("t2_hold_dir", direction, UP);
      chk("t2_hold_tick", {3'b000, move_tick}, 4'b0001);

      // 3: reversal rejected
      do_reset(2);
      btn[1] = 1'b1;
      run_to(10);
      chk("t3_rev_dir", direction, RIGHT);
      btn[1] = 1'b0;
      run_to(20);
      chk("t3_after_dir", direction, RIGHT);

      // 4: latest wins
      do_reset(2);
      btn[0] = 1'b1; step(); step();
      btn[3] = 1'b1;
      run_to(10);
      chk("t4_latest_dir", direction, DOWN);
      btn = 4'b0000;
      run_to(20);
      chk("t4_next_dir", direction, DOWN);

      // 5: simultaneous up+down, up has priority
      do_reset(2);
      btn = 4'b1001;
      run_to(10);
      chk("t5_prio_dir", direction, UP);
      btn = 4'b0000;

      // 6: down accepted on the commit edge while up is pending
      do_reset(2);
      step();
      btn[0] = 1'b1; step(); step();
      btn[3] = 1'b1;
      run_to(10);
      chk("t6_commit1_dir", direction, UP);
      chk("t6_commit1_tick", {3'b000, move_tick}, 4'b0001);
      btn = 4'b0000;
      run_to(20);
      chk("t6_commit2_dir", direction, DOWN);

      // 7: reset mid-period with up held
      do_reset(2);
      btn[0] = 1'b1;
      run_to(13);
      chk("t7_pre_dir", direction, UP);
      do_reset(3);
      run_to(10);
      chk("t7_post_dir", direction, UP);
      chk("t7_post_tick", {3'b000, move_tick}, 4'b0001);
      btn = 4'b0000;

      // random activity
      do_reset(2);
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
         if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
         else step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
